// File: rtl/regs_wport_arb.sv
// Register-file write-port arbiter: ex writeback, divider result, jtag debug write.
// Latency: write port is combinational (grant and we_o in the request cycle); hold_o is registered.
// Backpressure: ex is never stalled; div/jtag wait via ready, and a starving request raises hold_o for one cycle.
module regs_wport_arb #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    // ex writeback: single cycle, never stalled
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    // divider result
    input  logic              div_valid_i,
    output logic              div_ready_o,
    input  logic [ADDR_W-1:0] div_waddr_i,
    input  logic [DATA_W-1:0] div_wdata_i,
    // jtag debug write
    input  logic              jtag_valid_i,
    output logic              jtag_ready_o,
    input  logic [ADDR_W-1:0] jtag_addr_i,
    input  logic [DATA_W-1:0] jtag_wdata_i,
    // divider issue, marks the destination busy
    input  logic              div_issue_i,
    input  logic [ADDR_W-1:0] div_issue_rd_i,
    // id source operands
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic              raw_stall_o,
    output logic              hold_o,
    // register file write port
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(STARVE_MAX - 1);

    // rr_last_q: 1 = divider won the last div/jtag arbitration, 0 = jtag (or nothing since reset)
    logic              rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              hold_q, hold_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              ex_own;
    logic              div_gnt;
    logic              jtag_gnt;
    logic              any_gnt;
    logic              any_req;
    logic              div_hs;
    logic              stall_rs1;
    logic              stall_rs2;

    // A write from ex to x0 is discarded, so it does not occupy the port
    assign ex_own  = ex_we_i && (ex_waddr_i != '0);
    assign any_req = div_valid_i || jtag_valid_i;
    assign any_gnt = div_gnt || jtag_gnt;
    assign div_hs  = div_valid_i && div_gnt;

    // Arbitration: ex has absolute priority, otherwise round-robin between div and jtag
    always_comb begin
        div_gnt  = 1'b0;
        jtag_gnt = 1'b0;
        if (!ex_own) begin
            if (div_valid_i && jtag_valid_i) begin
                if (rr_last_q) begin
                    jtag_gnt = 1'b1;
                end else begin
                    div_gnt = 1'b1;
                end
            end else if (div_valid_i) begin
                div_gnt = 1'b1;
            end else if (jtag_valid_i) begin
                jtag_gnt = 1'b1;
            end
        end
    end

    assign div_ready_o  = div_gnt;
    assign jtag_ready_o = jtag_gnt;

    // Write port mux; a granted write to x0 is consumed but never reaches the regfile
    always_comb begin
        we_o    = 1'b0;
        waddr_o = '0;
        wdata_o = '0;
        if (ex_own) begin
            we_o    = 1'b1;
            waddr_o = ex_waddr_i;
            wdata_o = ex_wdata_i;
        end else if (div_gnt && (div_waddr_i != '0)) begin
            we_o    = 1'b1;
            waddr_o = div_waddr_i;
            wdata_o = div_wdata_i;
        end else if (jtag_gnt && (jtag_addr_i != '0)) begin
            we_o    = 1'b1;
            waddr_o = jtag_addr_i;
            wdata_o = jtag_wdata_i;
        end
    end

    // Round-robin pointer follows whichever of div/jtag was last granted
    always_comb begin
        rr_last_d = rr_last_q;
        if (div_gnt) begin
            rr_last_d = 1'b1;
        end else if (jtag_gnt) begin
            rr_last_d = 1'b0;
        end
    end

    // Starvation counter and one-shot hold request; hold fires only on the 7->8 style
    // crossing, so a saturated counter cannot retrigger it
    always_comb begin
        wait_d = wait_q;
        hold_d = 1'b0;
        if (any_gnt) begin
            wait_d = '0;
        end else if (any_req) begin
            if (wait_q != CNT_MAX) begin
                wait_d = wait_q + 1'b1;
            end
            if (wait_q == CNT_HOLD) begin
                hold_d = 1'b1;
            end
        end
    end

    // Scoreboard of divider destinations; an issue in the same cycle as the retiring
    // result for the same register wins, since the new op still owes a result
    always_comb begin
        busy_d = busy_q;
        if (div_hs) begin
            busy_d[div_waddr_i] = 1'b0;
        end
        if (div_issue_i && (div_issue_rd_i != '0)) begin
            busy_d[div_issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // RAW stall: a register retiring from the divider this cycle is covered by the regfile bypass
    always_comb begin
        stall_rs1 = (rs1_i != '0) && busy_q[rs1_i] && !(div_hs && (div_waddr_i == rs1_i));
        stall_rs2 = (rs2_i != '0) && busy_q[rs2_i] && !(div_hs && (div_waddr_i == rs2_i));
        raw_stall_o = stall_rs1 || stall_rs2;
    end

    assign hold_o = hold_q;

    // State registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b0;
            wait_q    <= '0;
            hold_q    <= 1'b0;
            busy_q    <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_regs_wport_arb.sv
// Directed bench for regs_wport_arb: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_regs_wport_arb;

    logic        clk;
    logic        rst;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        div_valid_i;
    logic        div_ready_o;
    logic [4:0]  div_waddr_i;
    logic [31:0] div_wdata_i;
    logic        jtag_valid_i;
    logic        jtag_ready_o;
    logic [4:0]  jtag_addr_i;
    logic [31:0] jtag_wdata_i;
    logic        div_issue_i;
    logic [4:0]  div_issue_rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic        raw_stall_o;
    logic        hold_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int vectors = 0;
    int fails   = 0;

    regs_wport_arb #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_we_i        (ex_we_i),
        .ex_waddr_i     (ex_waddr_i),
        .ex_wdata_i     (ex_wdata_i),
        .div_valid_i    (div_valid_i),
        .div_ready_o    (div_ready_o),
        .div_waddr_i    (div_waddr_i),
        .div_wdata_i    (div_wdata_i),
        .jtag_valid_i   (jtag_valid_i),
        .jtag_ready_o   (jtag_ready_o),
        .jtag_addr_i    (jtag_addr_i),
        .jtag_wdata_i   (jtag_wdata_i),
        .div_issue_i    (div_issue_i),
        .div_issue_rd_i (div_issue_rd_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .raw_stall_o    (raw_stall_o),
        .hold_o         (hold_o),
        .we_o           (we_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
        div_valid_i = 0; div_waddr_i = 0; div_wdata_i = 0;
        jtag_valid_i = 0; jtag_addr_i = 0; jtag_wdata_i = 0;
        div_issue_i = 0; div_issue_rd_i = 0;
        rs1_i = 0; rs2_i = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
        smp();
        chk("rst_we", we_o, 0);
        chk("rst_waddr", waddr_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_hold", hold_o, 0);
        chk("rst_stall", raw_stall_o, 0);
        chk("rst_div_rdy", div_ready_o, 0);
        chk("rst_jtag_rdy", jtag_ready_o, 0);

        // ---------------- 1: ex owns the port over div ----------------
        nxt();
        ex_we_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hA5;
        div_valid_i = 1; div_waddr_i = 6; div_wdata_i = 32'h66;
        smp();
        chk("t1_ex_we", we_o, 1);
        chk("t1_ex_waddr", waddr_o, 5);
        chk("t1_ex_wdata", wdata_o, 32'hA5);
        chk("t1_div_rdy_blocked", div_ready_o, 0);
        nxt();
        ex_we_i = 0;
        smp();
        chk("t1_div_rdy", div_ready_o, 1);
        chk("t1_div_we", we_o, 1);
        chk("t1_div_waddr", waddr_o, 6);
        chk("t1_div_wdata", wdata_o, 32'h66);
        nxt();
        idle();

        // ---------------- 2: round-robin div/jtag from reset ----------------
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        div_valid_i = 1; div_waddr_i = 7; div_wdata_i = 32'h77;
        jtag_valid_i = 1; jtag_addr_i = 8; jtag_wdata_i = 32'h88;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t2_div_rdy", div_ready_o, (i % 2 == 0) ? 1 : 0);
            chk("t2_jtag_rdy", jtag_ready_o, (i % 2 == 1) ? 1 : 0);
            chk("t2_waddr", waddr_o, (i % 2 == 0) ? 7 : 8);
            nxt();
        end
        idle();
        smp();
        chk("t2_idle_we", we_o, 0);
        nxt();

        // ---------------- 3: jtag starved by ex -> hold at cycle 8 ----------------
        ex_we_i = 1; ex_waddr_i = 1; ex_wdata_i = 32'h11;
        jtag_valid_i = 1; jtag_addr_i = 9; jtag_wdata_i = 32'h99;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("t3_hold_low", hold_o, 0);
            chk("t3_jtag_blocked", jtag_ready_o, 0);
            chk("t3_ex_waddr", waddr_o, 1);
            nxt();
        end
        ex_we_i = 0;
        smp();
        chk("t3_hold_high", hold_o, 1);
        chk("t3_jtag_rdy", jtag_ready_o, 1);
        chk("t3_jtag_waddr", waddr_o, 9);
        chk("t3_jtag_wdata", wdata_o, 32'h99);
        nxt();
        idle();
        smp();
        chk("t3_hold_after", hold_o, 0);
        nxt();

        // ---------------- 4: RAW stall on divider destination ----------------
        div_issue_i = 1; div_issue_rd_i = 3; rs1_i = 3;
        smp();
        chk("t4_issue_cycle_stall", raw_stall_o, 0);
        nxt();
        div_issue_i = 0;
        smp();
        chk("t4_stall_rs1", raw_stall_o, 1);
        nxt();
        rs1_i = 0; rs2_i = 3;
        smp();
        chk("t4_stall_rs2", raw_stall_o, 1);
        nxt();
        rs2_i = 0; rs1_i = 3;
        div_valid_i = 1; div_waddr_i = 3; div_wdata_i = 32'h33;
        smp();
        chk("t4_hs_rdy", div_ready_o, 1);
        chk("t4_hs_stall", raw_stall_o, 0);
        chk("t4_hs_waddr", waddr_o, 3);
        nxt();
        div_valid_i = 0;
        smp();
        chk("t4_cleared_stall", raw_stall_o, 0);
        nxt();
        idle();

        // ---------------- 5: set wins over clear; x0 writes ----------------
        div_issue_i = 1; div_issue_rd_i = 4;
        nxt();
        div_valid_i = 1; div_waddr_i = 4; div_wdata_i = 32'h44;
        ex_we_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'hDEAD;
        rs1_i = 4;
        smp();
        chk("t5_div_rdy", div_ready_o, 1);
        chk("t5_we", we_o, 1);
        chk("t5_waddr", waddr_o, 4);
        chk("t5_wdata", wdata_o, 32'h44);
        chk("t5_hs_stall", raw_stall_o, 0);
        nxt();
        idle();
        rs1_i = 4;
        smp();
        chk("t5_still_busy", raw_stall_o, 1);
        nxt();
        ex_we_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'hBEEF;
        smp();
        chk("t5_ex_x0_we", we_o, 0);
        nxt();
        ex_we_i = 0;
        div_valid_i = 1; div_waddr_i = 0; div_wdata_i = 32'h12;
        smp();
        chk("t5_div_x0_rdy", div_ready_o, 1);
        chk("t5_div_x0_we", we_o, 0);
        nxt();
        div_waddr_i = 4; div_wdata_i = 32'h45;
        nxt();
        div_valid_i = 0;
        smp();
        chk("t5_busy4_cleared", raw_stall_o, 0);
        nxt();
        idle();

        // ---------------- 6: reset mid-stall ----------------
        div_issue_i = 1; div_issue_rd_i = 3; rs1_i = 3;
        ex_we_i = 1; ex_waddr_i = 1; ex_wdata_i = 32'h11;
        jtag_valid_i = 1; jtag_addr_i = 9; jtag_wdata_i = 32'h99;
        nxt();
        div_issue_i = 0;
        smp();
        chk("t6_pre_stall", raw_stall_o, 1);
        nxt();
        nxt();
        nxt();
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("t6_post_hold", hold_o, 0);
            chk("t6_post_stall", raw_stall_o, 0);
            nxt();
        end
        ex_we_i = 0;
        smp();
        chk("t6_hold_full_window", hold_o, 1);
        chk("t6_jtag_rdy", jtag_ready_o, 1);
        nxt();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
